ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit feeding the decode stage. Generates the PC, issues word reads to instruction memory over a request/grant handshake, and buffers returned words in a 2-entry queue. It presents one instruction plus its next-PC to decode each cycle and honours decode's stall and flow-change (branch/jump redirect) signals. When no valid word is available, it inserts a NOP bubble.

## Interface
- `PC_W`, 16: PC / instruction-memory word-address width.
- `RESET_PC`, 0: first fetch address after reset.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `stall_IM_ID` in 1: decode cannot accept an instruction this cycle.
- `flow_change_ID_EX` in 1: redirect; the branch or jump in EX is taken.
- `dst_ID_EX` in PC_W: redirect target, valid with `flow_change_ID_EX`.
- `im_req` out 1: read request.
- `im_addr` out PC_W: read word address.
- `im_gnt` in 1: memory accepts the request this cycle.
- `im_rdata` in 32: read data, valid exactly 1 cycle after grant.
- `instr` out 32: instruction to decode.
- `nxt_pc` out PC_W: address of `instr` + 1, paired with `instr`.
- `instr_vld` out 1: high when `instr` is a real fetched word; low when it is a bubble.

## Operation
- Word-addressed PC.
- Request rule: `im_req` = !rst_state & (queue occupancy + outstanding < 2) & !`flow_change_ID_EX`. `im_addr` = pc.
- Grant: on `im_req & im_gnt`, pc <= pc+1 (wraps modulo 2^PC_W), outstanding <= 1, and the current epoch is tagged.
- Response: 1 cycle after a grant, {`im_rdata`, granted addr+1} is pushed into the queue if its epoch tag matches the current epoch; otherwise it is discarded.
- Delivery:
  - `instr`/`nxt_pc` come combinationally from the queue head.
  - When the queue is empty: `instr` = NOP (32'h0000_B000), `instr_vld` = 0, `nxt_pc` = pc.
- Pop: the head pops when `!stall_IM_ID` and the queue is non-empty.
- Push and pop in the same cycle: both happen and occupancy is unchanged. Push into a full queue cannot occur because of the request rule. Push into an empty queue is not bypassed in the same cycle.
- Redirect (`flow_change_ID_EX` = 1):
  - pc <= `dst_ID_EX`.
  - The queue is flushed.
  - The epoch toggles, so the in-flight response is dropped.
  - No request is issued that cycle.
  - Redirect overrides a simultaneous grant, push and pop.
- Decode discards the two younger instructions itself. This block only guarantees that no pre-redirect word is delivered after the redirect cycle.
- Stall with the queue full: requests stop and `instr` holds steady.
- Memory never grants (`im_gnt` stuck low): bubbles are delivered indefinitely, and pc holds.

## Timing
- Reset values:
  - pc = RESET_PC; queue empty; outstanding = 0; epoch = 0.
  - `im_req` = 0 in the reset cycle, 1 from the first cycle after deassert.
  - `instr` = NOP, `instr_vld` = 0, `nxt_pc` = RESET_PC.
- Latency: grant at cycle N gives the word visible on `instr` at N+2. Steady-state throughput is 1 instruction/cycle with `im_gnt` tied high.
- Redirect at cycle R: `im_req` with `im_addr` = target at R+1. With immediate grant, the target word appears at R+3.
- Reset asserted mid-operation: all state clears asynchronously, and the pending response is ignored.

## Configuration
- `IFETCH_PERF_EN` defined: adds 32-bit outputs `fetch_cnt` (pops of valid words) and `bubble_cnt` (cycles with `!stall_IM_ID` and an empty queue).
  - Both saturate at 32'hFFFF_FFFF.
  - Both reset to 0.
- `IFETCH_PERF_EN` undefined: the ports and counters do not exist.

## Structure
- Shared package `pipe_pkg`:
  - `NOP_INSTR` (32'h0000_B000).
  - Opcode constants used by decode.
  - `fetch_entry_t` {instr[31:0], nxt_pc[PC_W-1:0]}.
- One sub-module, `ifetch_q`: 2-entry FIFO of `fetch_entry_t` with push, pop, flush, count, and head outputs. The PC, epoch and handshake logic live in `ifetch`.

## Test plan
- Reset release with `im_gnt`=1 and memory[i]=i+0x1000 → `instr` = 0x1000, 0x1001, 0x1002… starting at cycle 2, `nxt_pc` = 1, 2, 3…, and no bubbles thereafter.
- `stall_IM_ID` held 5 cycles mid-stream → `instr` holds steady, `im_req` drops once occupancy + outstanding = 2, and the stream resumes with no word lost or duplicated.
- `flow_change_ID_EX` with `dst_ID_EX`=0x0040 while a response is in flight and the queue is full → the next non-bubble `instr` is mem[0x40], and stale words are never delivered.
- `im_gnt` low for 3 cycles → 3 bubbles (`instr_vld`=0, NOP), then normal delivery with pc unchanged.
- pc=0xFFFF sequential fetch → the next `im_addr` is 0x0000 and `nxt_pc` for that word is 0x0000.
- With `IFETCH_PERF_EN`: 10 valid pops plus 4 bubble cycles → `fetch_cnt`=10, `bubble_cnt`=4; `rst` pulse → both 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions used by fetch and decode.
//   NOP_INSTR     : bubble instruction inserted when fetch has nothing valid
//   opcode_e      : major opcode field (instr[15:12]) decoded by ID
//   fetch_entry_t : one buffered fetch result {instr, nxt_pc}
// FETCH_PC_W sets the width of the nxt_pc field carried in fetch_entry_t.
package pipe_pkg;

  localparam int unsigned FETCH_PC_W = 16;

  typedef enum logic [3:0] {
    OpAlu  = 4'h0,
    OpAluI = 4'h1,
    OpLoad = 4'h2,
    OpStor = 4'h3,
    OpBr   = 4'h8,
    OpJmp  = 4'h9,
    OpNop  = 4'hB
  } opcode_e;

  localparam logic [31:0] NOP_INSTR = {16'h0000, OpNop, 12'h000};

  typedef struct packed {
    logic [31:0]           instr;
    logic [FETCH_PC_W-1:0] nxt_pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_q.sv
// Two-entry FIFO of fetch_entry_t between the memory response and decode.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push/wdata : enqueue one entry (ignored when full)
//   pop        : dequeue the head (ignored when empty)
//   flush      : empty the queue; wins over push and pop
//   count      : current occupancy (0..2)
//   empty      : occupancy is zero
//   head       : oldest entry, meaningful only when !empty
module ifetch_q
  import pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_push  = push & (count_q != 2'd2) & !flush;
    do_pop   = pop & (count_q != 2'd0) & !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every use of the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign count = count_q;
  assign empty = (count_q == 2'd0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: PC generation, request/grant handshake to
// instruction memory, 2-entry buffering and delivery of {instr, nxt_pc}
// to decode, with bubble (NOP) insertion and redirect handling.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   stall_IM_ID                    : decode cannot take an instruction
//   flow_change_ID_EX, dst_ID_EX   : taken branch/jump redirect and target
//   im_req, im_addr, im_gnt        : memory read request handshake
//   im_rdata                       : read data, one cycle after grant
//   instr, nxt_pc, instr_vld       : instruction to decode, its pc+1, valid
// Optional (IFETCH_PERF_EN defined):
//   fetch_cnt  : saturating count of valid words popped by decode
//   bubble_cnt : saturating count of cycles decode wanted a word but none
// PC_W must not exceed pipe_pkg::FETCH_PC_W.
module ifetch
  import pipe_pkg::*;
#(
  parameter int unsigned     PC_W     = FETCH_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_IM_ID,
  input  logic            flow_change_ID_EX,
  input  logic [PC_W-1:0] dst_ID_EX,
  output logic            im_req,
  output logic [PC_W-1:0] im_addr,
  input  logic            im_gnt,
  input  logic [31:0]     im_rdata,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] nxt_pc,
  output logic            instr_vld
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     bubble_cnt
`endif
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic            out_q, out_d;
  logic            out_epoch_q, out_epoch_d;
  logic [PC_W-1:0] out_addr_q, out_addr_d;

  logic            grant;
  logic            q_push, q_pop, q_empty;
  logic [1:0]      q_count, q_occ;
  fetch_entry_t    q_wdata, q_head;

  always_comb begin
    // A redirect flushes the queue, so it also cancels this cycle's pop.
    q_pop = !stall_IM_ID & !q_empty & !flow_change_ID_EX;
    // Occupancy excludes the slot being freed by this cycle's pop; that is
    // what lets a grant every cycle sustain one instruction per cycle.
    q_occ  = q_count - {1'b0, q_pop};
    im_req = !rst & !flow_change_ID_EX & ((q_occ + {1'b0, out_q}) < 2'd2);
    im_addr = pc_q;
    grant   = im_req & im_gnt;

    // Responses from an older epoch belong to a squashed path.
    q_push         = out_q & (out_epoch_q == epoch_q) & !flow_change_ID_EX;
    q_wdata.instr  = im_rdata;
    q_wdata.nxt_pc = FETCH_PC_W'(out_addr_q + PC_W'(1));

    pc_d        = pc_q;
    epoch_d     = epoch_q;
    out_d       = grant;
    out_epoch_d = out_epoch_q;
    out_addr_d  = out_addr_q;
    if (grant) begin
      pc_d        = pc_q + PC_W'(1);
      out_epoch_d = epoch_q;
      out_addr_d  = pc_q;
    end
    if (flow_change_ID_EX) begin
      pc_d    = dst_ID_EX;
      epoch_d = ~epoch_q;
    end

    if (q_empty) begin
      instr     = NOP_INSTR;
      nxt_pc    = pc_q;
      instr_vld = 1'b0;
    end else begin
      instr     = q_head.instr;
      nxt_pc    = PC_W'(q_head.nxt_pc);
      instr_vld = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      epoch_q     <= 1'b0;
      out_q       <= 1'b0;
      out_epoch_q <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      out_q       <= out_d;
      out_epoch_q <= out_epoch_d;
      out_addr_q  <= out_addr_d;
    end
  end

  ifetch_q u_q (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .flush (flow_change_ID_EX),
    .count (q_count),
    .empty (q_empty),
    .head  (q_head)
  );

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (q_pop && fetch_cnt_q != 32'hFFFF_FFFF) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (!stall_IM_ID && q_empty && bubble_cnt_q != 32'hFFFF_FFFF) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
  import pipe_pkg::*;

  localparam int unsigned PC_W     = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flow;
  logic [15:0] dst;
  logic        im_req;
  logic [15:0] im_addr;
  logic        im_gnt;
  logic [31:0] im_rdata;
  logic [31:0] instr;
  logic [15:0] nxt_pc;
  logic        instr_vld;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  ifetch #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_IM_ID       (stall),
    .flow_change_ID_EX (flow),
    .dst_ID_EX         (dst),
    .im_req            (im_req),
    .im_addr           (im_addr),
    .im_gnt            (im_gnt),
    .im_rdata          (im_rdata),
    .instr             (instr),
    .nxt_pc            (nxt_pc),
    .instr_vld         (instr_vld)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_cnt         (fetch_cnt),
    .bubble_cnt        (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'h0000_1000 + {16'h0000, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: answers a granted request with its word one cycle later.
  logic        fire_s;
  logic [15:0] fire_addr;
  initial begin
    im_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      fire_s    = im_req & im_gnt;
      fire_addr = im_addr;
      @(posedge clk);
      #1;
      im_rdata = fire_s ? mem_word(fire_addr) : 32'hDEAD_BEEF;
    end
  end

  // Reference model: the delivered stream is the sequential address stream
  // starting at the reset PC or at the latest redirect target. Each granted
  // fetch appends its expected result; a redirect discards everything
  // not yet delivered.
  typedef struct {
    logic [31:0] instr;
    logic [15:0] nxt_pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] fetch_addr  = RESET_PC;
  int          mdl_bubbles = 0;
  int          mdl_pops    = 0;
  int          total_pops  = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      fetch_addr  = RESET_PC;
      mdl_bubbles = 0;
    end else begin
      if (!instr_vld) begin
        check("bubble_instr", instr, NOP_INSTR);
        check("bubble_nxt_pc", {16'h0, nxt_pc}, {16'h0, fetch_addr});
        if (!stall) mdl_bubbles++;
      end
      if (flow) begin
        check("req_on_redirect", {31'h0, im_req}, 32'h0);
        exp_q.delete();
        fetch_addr = dst;
      end else if (im_req && im_gnt) begin
        exp_t e;
        check("im_addr", {16'h0, im_addr}, {16'h0, fetch_addr});
        e.instr  = mem_word(fetch_addr);
        e.nxt_pc = fetch_addr + 16'd1;
        exp_q.push_back(e);
        fetch_addr = fetch_addr + 16'd1;
      end
    end
  end

  // Monitor: every word decode actually takes must be the next expected one.
  always @(negedge clk) begin
    if (rst) begin
      mdl_pops = 0;
    end else if (instr_vld && !stall && !flow) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_word: got %h expected none at %0t", instr, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("deliver_instr", instr, e.instr);
        check("deliver_nxt_pc", {16'h0, nxt_pc}, {16'h0, e.nxt_pc});
        mdl_pops++;
        total_pops++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] hold_v;
  int          nb;
  logic        seen;

  initial begin
    rst    = 1'b1;
    stall  = 1'b0;
    flow   = 1'b0;
    dst    = '0;
    im_gnt = 1'b0;
    repeat (2) @(posedge clk);

    @(negedge clk);
    check("rst_req", {31'h0, im_req}, 32'h0);
    check("rst_instr", instr, NOP_INSTR);
    check("rst_vld", {31'h0, instr_vld}, 32'h0);
    check("rst_nxt_pc", {16'h0, nxt_pc}, {16'h0, RESET_PC});

    // Reset release with grant tied high: word 0 appears on cycle 2.
    im_gnt = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("req_after_rst", {31'h0, im_req}, 32'h1);
    check("addr_after_rst", {16'h0, im_addr}, {16'h0, RESET_PC});
    step();
    @(negedge clk);
    check("cycle1_bubble", {31'h0, instr_vld}, 32'h0);
    step();
    @(negedge clk);
    check("first_vld", {31'h0, instr_vld}, 32'h1);
    check("first_instr", instr, 32'h0000_1000);
    check("first_nxt_pc", {16'h0, nxt_pc}, 32'h1);
    for (int i = 0; i < 12; i++) begin
      step();
      @(negedge clk);
      check("stream_no_bubble", {31'h0, instr_vld}, 32'h1);
    end

    // Stall for 5 cycles mid-stream.
    step();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) hold_v = instr;
      if (i >= 1) check("stall_req_drop", {31'h0, im_req}, 32'h0);
      if (i == 4) begin
        check("stall_hold", instr, hold_v);
        check("stall_vld", {31'h0, instr_vld}, 32'h1);
      end
      step();
    end
    stall = 1'b0;
    repeat (4) step();

    // Redirect to 0x40 with a response in flight.
    flow = 1'b1;
    dst  = 16'h0040;
    step();
    flow = 1'b0;
    @(negedge clk);
    check("redir_req", {31'h0, im_req}, 32'h1);
    check("redir_addr", {16'h0, im_addr}, 32'h40);
    check("redir_no_stale1", {31'h0, instr_vld}, 32'h0);
    step();
    @(negedge clk);
    check("redir_no_stale2", {31'h0, instr_vld}, 32'h0);
    step();
    @(negedge clk);
    check("redir_vld", {31'h0, instr_vld}, 32'h1);
    check("redir_instr", instr, mem_word(16'h0040));
    check("redir_nxt_pc", {16'h0, nxt_pc}, 32'h41);

    // Grant low for 3 cycles costs exactly 3 bubbles.
    repeat (4) step();
    im_gnt = 1'b0;
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!instr_vld) nb++;
      step();
      if (i == 2) im_gnt = 1'b1;
    end
    check("gnt_low_bubbles", nb, 32'd3);

    // Sequential fetch across the top of the address space.
    flow = 1'b1;
    dst  = 16'hFFFD;
    step();
    flow = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_vld && instr == mem_word(16'hFFFF) && nxt_pc == 16'h0000) seen = 1'b1;
      step();
    end
    check("wrap_seen", {31'h0, seen}, 32'h1);

    // Asynchronous reset in the middle of a cycle with a response pending.
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_vld", {31'h0, instr_vld}, 32'h0);
    check("async_rst_nxt_pc", {16'h0, nxt_pc}, {16'h0, RESET_PC});
    check("async_rst_req", {31'h0, im_req}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    step();
    @(negedge clk);
    check("restart_instr", instr, mem_word(RESET_PC));

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      stall  = ($urandom % 4) == 0;
      im_gnt = ($urandom % 4) != 0;
      flow   = ($urandom % 25) == 0;
      dst    = (($urandom % 6) == 0) ? 16'hFFFE : 16'($urandom);
      step();
    end
    stall = 1'b1;
    flow  = 1'b0;
    step();
    step();
    @(negedge clk);
    check("progress", {31'h0, total_pops > 300}, 32'h1);
`ifdef IFETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, mdl_pops);
    check("bubble_cnt", bubble_cnt, mdl_bubbles);
    step();
    rst = 1'b1;
    #1;
    check("fetch_cnt_rst", fetch_cnt, 32'h0);
    check("bubble_cnt_rst", bubble_cnt, 32'h0);
    step();
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
